lifo_fifo_buf: RTL and testbench

Parametrised single-clock storage buffer, the next generation of the team's 16-bit stack: configurable width and depth, run-time selectable LIFO or FIFO ordering, occupancy count, simultaneous push/pop, synchronous flush and one-cycle overflow/underflow flags. Sits between producer and consumer datapaths wherever operands are buffered. Examples are expression-evaluation stacks and command queues.

---
 rtl/lifo_fifo_pkg.sv | 18 +
 rtl/buf_regfile.sv | 30 +++
 rtl/lifo_fifo_buf.sv | 136 +++++++++++++
 tb/tb_lifo_fifo_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_fifo_pkg.sv
// Shared definitions for the lifo_fifo_buf storage buffer.
//   MODE_LIFO / MODE_FIFO : encodings of the ordering-mode bit
//   op_t                  : per-cycle operation decoded from wn/rn/full/empty
package lifo_fifo_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,    // pop and push on the same edge, occupancy unchanged
    OP_DROP,    // push against a full buffer
    OP_REFUSE   // pop against an empty buffer
  } op_t;

endpackage

// File: rtl/buf_regfile.sv
// Storage array for lifo_fifo_buf: DEPTH words of DATA_W bits.
//   clk   : write clock
//   we    : write enable, samples wdata into mem[waddr] on the rising edge
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : asynchronous read of mem[raddr]
// The array has no reset; the owner tracks which entries are valid.
module buf_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buf.sv
// Single-clock buffer with run-time selectable LIFO/FIFO ordering.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : requested ordering (0 LIFO, 1 FIFO); adopted only when empty or on clr
//   clr        : synchronous flush, overrides wn/rn
//   wn, in     : push request and data
//   rn         : pop request
//   out        : registered pop data, held between pops
//   full/empty : derived from count
//   count      : occupancy
//   ovf / udf  : one-cycle pulses for a dropped push / refused pop
//   mode_q     : ordering currently in force
module lifo_fifo_buf
  import lifo_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              clr,
  input  logic              wn,
  input  logic              rn,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              udf,
  output logic              mode_q
);

  localparam int PTR_W = $clog2(DEPTH);

  op_t               op;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [PTR_W-1:0]  sp_lo, top, waddr, raddr;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] rdata;
  logic              we, load_out, ovf_nxt, udf_nxt;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // In LIFO mode the stack pointer is count itself; only its low bits
  // index storage because a push is never performed at count == DEPTH.
  assign sp_lo = count[PTR_W-1:0];
  assign top   = sp_lo - PTR_W'(1);

  always_comb begin
    op = OP_IDLE;
    if (wn && rn)  op = empty ? OP_PUSH   : OP_SWAP;
    else if (wn)   op = full  ? OP_DROP   : OP_PUSH;
    else if (rn)   op = empty ? OP_REFUSE : OP_POP;
  end

  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    we         = 1'b0;
    load_out   = 1'b0;
    ovf_nxt    = 1'b0;
    udf_nxt    = 1'b0;
    waddr      = (mode_q == MODE_FIFO) ? wr_ptr : sp_lo;
    raddr      = (mode_q == MODE_FIFO) ? rd_ptr : top;
    if (clr) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      ovf_nxt = (op == OP_DROP);
      // A pop against empty is refused even when a push accompanies it.
      udf_nxt = rn && empty;
      case (op)
        OP_PUSH: begin
          we        = 1'b1;
          count_nxt = count + CNT_W'(1);
        end
        OP_POP: begin
          load_out  = 1'b1;
          count_nxt = count - CNT_W'(1);
        end
        OP_SWAP: begin
          we       = 1'b1;
          load_out = 1'b1;
        end
        default: ;
      endcase
      if (mode_q == MODE_FIFO) begin
        if (we)       wr_ptr_nxt = wr_ptr + PTR_W'(1);
        if (load_out) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end else if (op == OP_SWAP) begin
        // LIFO swap overwrites the old top, which is read out on the same edge.
        waddr = top;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      mode_q <= MODE_LIFO;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      if (load_out) out <= rdata;
      // Mode switches only across an empty boundary, so FIFO pointers
      // are always equal whenever FIFO ordering takes over.
      if (clr || count_nxt == '0) mode_q <= mode;
    end
  end

  buf_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (in),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Self-checking bench for lifo_fifo_buf: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_lifo_fifo_buf;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode, clr, wn, rn;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              full, empty, ovf, udf, mode_q;
  logic [CNT_W-1:0]  count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] out_m;
  logic              ovf_m, udf_m, mode_m;

  always #5 clk = ~clk;

  lifo_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .clr    (clr),
    .wn     (wn),
    .rn     (rn),
    .in     (in),
    .out    (out),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .ovf    (ovf),
    .udf    (udf),
    .mode_q (mode_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},    32'(out),    32'(out_m));
    chk({tag, ".count"},  32'(count),  32'(q.size()));
    chk({tag, ".empty"},  32'(empty),  32'(q.size() == 0));
    chk({tag, ".full"},   32'(full),   32'(q.size() == DEPTH));
    chk({tag, ".ovf"},    32'(ovf),    32'(ovf_m));
    chk({tag, ".udf"},    32'(udf),    32'(udf_m));
    chk({tag, ".mode_q"}, 32'(mode_q), 32'(mode_m));
  endtask

  task automatic model_reset();
    q.delete();
    out_m  = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
    mode_m = 1'b0;
  endtask

  // Behaviour of one clock edge, stated in terms of the stored sequence.
  task automatic model_edge(input logic w, input logic r, input logic c,
                            input logic m, input logic [DATA_W-1:0] d);
    bit e, f;
    e = (q.size() == 0);
    f = (q.size() == DEPTH);
    ovf_m = 1'b0;
    udf_m = 1'b0;
    if (c) begin
      q.delete();
      mode_m = m;
    end else begin
      if (w && r) begin
        if (e) begin
          q.push_back(d);
          udf_m = 1'b1;
        end else if (mode_m == 1'b0) begin
          out_m = q[q.size()-1];
          q[q.size()-1] = d;
        end else begin
          out_m = q.pop_front();
          q.push_back(d);
        end
      end else if (w) begin
        if (f) ovf_m = 1'b1;
        else   q.push_back(d);
      end else if (r) begin
        if (e)                udf_m = 1'b1;
        else if (mode_m == 0) out_m = q.pop_back();
        else                  out_m = q.pop_front();
      end
      if (q.size() == 0) mode_m = m;
    end
  endtask

  task automatic step(input string tag, input logic w, input logic r, input logic c,
                      input logic m, input logic [DATA_W-1:0] d);
    wn = w; rn = r; clr = c; mode = m; in = d;
    @(posedge clk);
    model_edge(w, r, c, m, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] vals [7];
    vals = '{16'd100, 16'd150, 16'd200, 16'd40, 16'd70, 16'd65, 16'd15};
    rst_n = 1'b0; mode = 1'b0; clr = 1'b0; wn = 1'b0; rn = 1'b0; in = '0;
    model_reset();
    #1;
    chk("reset.out", 32'(out), 32'd0);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.full", 32'(full), 32'd0);
    chk("reset.mode_q", 32'(mode_q), 32'd0);
    chk("reset.flags", 32'({ovf, udf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LIFO ordering and underflow
    for (int i = 0; i < 7; i++) step("lifo_push", 1, 0, 0, 0, vals[i]);
    for (int i = 0; i < 7; i++) begin
      step("lifo_pop", 0, 1, 0, 0, '0);
      chk("lifo_order", 32'(out), 32'(vals[6-i]));
    end
    chk("lifo_drained", 32'(empty), 32'd1);
    step("lifo_udf", 0, 1, 0, 0, '0);
    chk("lifo_udf_flag", 32'(udf), 32'd1);
    chk("lifo_udf_hold", 32'(out), 32'd100);

    // FIFO ordering
    step("to_fifo", 0, 0, 0, 1, '0);
    chk("fifo_mode", 32'(mode_q), 32'd1);
    for (int i = 0; i < 7; i++) step("fifo_push", 1, 0, 0, 1, vals[i]);
    for (int i = 0; i < 7; i++) begin
      step("fifo_pop", 0, 1, 0, 1, '0);
      chk("fifo_order", 32'(out), 32'(vals[i]));
    end

    // FIFO pointer wrap with interleaved traffic
    for (int i = 0; i < 12; i++) begin
      step("wrap_push", 1, 0, 0, 1, 16'(300 + i));
      if (i % 2 == 1) step("wrap_pop", 0, 1, 0, 1, '0);
    end
    while (q.size() > 0) step("wrap_drain", 0, 1, 0, 1, '0);

    // Full and overflow in LIFO
    step("to_lifo", 0, 0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 0, 16'(i));
    step("ovf_push", 1, 0, 0, 0, 16'd9);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    step("ovf_clear", 0, 0, 0, 0, '0);
    chk("ovf_pulse", 32'(ovf), 32'd0);
    for (int i = 8; i >= 1; i--) begin
      step("full_pop", 0, 1, 0, 0, '0);
      chk("full_order", 32'(out), 32'(i));
    end

    // Simultaneous push/pop in LIFO
    step("swap_push", 1, 0, 0, 0, 16'd10);
    step("swap_push", 1, 0, 0, 0, 16'd20);
    step("lifo_swap", 1, 1, 0, 0, 16'd30);
    chk("lifo_swap_out", 32'(out), 32'd20);
    step("swap_pop", 0, 1, 0, 0, '0);
    chk("swap_pop_out", 32'(out), 32'd30);
    step("swap_pop", 0, 1, 0, 0, '0);

    // Simultaneous push/pop on a full FIFO
    step("to_fifo2", 0, 0, 0, 1, '0);
    for (int i = 1; i <= 8; i++) step("ffill", 1, 0, 0, 1, 16'(i));
    step("fifo_swap", 1, 1, 0, 1, 16'd9);
    chk("fifo_swap_out", 32'(out), 32'd1);
    chk("fifo_swap_ovf", 32'(ovf), 32'd0);
    while (q.size() > 0) step("fdrain", 0, 1, 0, 1, '0);

    // Push and pop on empty
    step("empty_swap", 1, 1, 0, 1, 16'd55);
    chk("empty_swap_udf", 32'(udf), 32'd1);
    chk("empty_swap_cnt", 32'(count), 32'd1);
    step("empty_swap_pop", 0, 1, 0, 0, '0);

    // Mode deferral
    for (int i = 0; i < 3; i++) step("defer_push", 1, 0, 0, 0, 16'(70 + i));
    for (int i = 0; i < 3; i++) step("defer_pop", 0, 1, 0, 1, '0);
    chk("defer_final", 32'(mode_q), 32'd1);
    step("back_lifo", 0, 0, 0, 0, '0);

    // Flush beats a simultaneous push
    for (int i = 0; i < 5; i++) step("clr_fill", 1, 0, 0, 0, 16'(90 + i));
    step("clr", 1, 0, 1, 0, 16'hBEEF);
    chk("clr_empty", 32'(empty), 32'd1);

    // Asynchronous reset between edges
    step("to_fifo3", 0, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) step("ar_fill", 1, 0, 0, 1, 16'(40 + i));
    step("ar_pop", 0, 1, 0, 1, '0);
    step("ar_push", 1, 0, 0, 1, 16'd44);
    wn = 1'b0; rn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    step("post_rst_push", 1, 0, 0, 1, 16'd501);
    step("post_rst_push", 1, 0, 0, 1, 16'd502);
    step("post_rst_pop", 0, 1, 0, 1, '0);
    chk("post_rst_lifo", 32'(out), 32'd502);
    step("post_rst_pop", 0, 1, 0, 1, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic w, r, c, m;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 31) == 0);
      m = ($urandom_range(0, 3) == 0) ? ~mode : mode;
      step("rand", w, r, c, m, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
